// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage of a 4-stage pipeline (IF/ID/EXE/WB).
//             Holds the PC, issues requests to a synchronous (1-cycle latency)
//             instruction SRAM and hands {inst, pc} to ID over a
//             valid/allowin handshake. Accepts branch/jump redirects from ID
//             and buffers the fetched word while ID stalls.
//  Ports    : clk_i               clock, rising edge
//             resetn_i            asynchronous active-low reset
//             ds_allowin_i        ID can accept an instruction this cycle
//             br_taken_i          redirect pulse from ID
//             br_target_i         redirect address (valid with br_taken_i)
//             fs_to_ds_valid_o    fs_to_ds_bus_o holds a valid instruction
//             fs_to_ds_bus_o      {inst[31:0], pc[31:0]}
//             inst_sram_en_o      read request strobe
//             inst_sram_we_o      write enable (always 0)
//             inst_sram_addr_o    request address (nextpc)
//             inst_sram_wdata_o   write data (always 0)
//             inst_sram_rdata_i   read data, valid the cycle after a request
//  Revision : 1.0  initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1bfffffc,
  parameter int unsigned FS_BUS_W = 64
) (
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                ds_allowin_i,
  input  logic                br_taken_i,
  input  logic [31:0]         br_target_i,
  output logic                fs_to_ds_valid_o,
  output logic [FS_BUS_W-1:0] fs_to_ds_bus_o,
  output logic                inst_sram_en_o,
  output logic                inst_sram_we_o,
  output logic [31:0]         inst_sram_addr_o,
  output logic [31:0]         inst_sram_wdata_o,
  input  logic [31:0]         inst_sram_rdata_i
);

  // State
  logic        pre_valid_q, pre_valid_d;
  logic        fs_valid_q,  fs_valid_d;
  logic [31:0] fs_pc_q,     fs_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_inst_q,  buf_inst_d;

  // Combinational
  logic [31:0] nextpc;
  logic        fs_allowin;
  logic        fetch_en;
  logic [31:0] fs_inst;

  always_comb begin
    nextpc     = br_taken_i ? br_target_i : (fs_pc_q + 32'd4);
    // A redirect always opens IF: the current instruction is wrong-path and
    // gets squashed, so the target can be requested even while ID stalls.
    fs_allowin = !fs_valid_q || ds_allowin_i || br_taken_i;
    fetch_en   = pre_valid_q && fs_allowin;
    // The SRAM only presents data in the cycle after a request, so once ID
    // has stalled for a cycle the word must come from the local buffer.
    fs_inst    = buf_valid_q ? buf_inst_q : inst_sram_rdata_i;
  end

  always_comb begin
    pre_valid_d = 1'b1;
    fs_valid_d  = fs_valid_q;
    fs_pc_d     = fs_pc_q;
    buf_valid_d = buf_valid_q;
    buf_inst_d  = buf_inst_q;

    if (fetch_en) begin
      fs_pc_d    = nextpc;
      fs_valid_d = 1'b1;
    end else if (fs_valid_q && ds_allowin_i) begin
      fs_valid_d = 1'b0;
    end

    if (fetch_en || br_taken_i) begin
      buf_valid_d = 1'b0;
    end else if (fs_valid_q && !ds_allowin_i && !buf_valid_q) begin
      // Capture only on the first stall cycle; later rdata is not meaningful.
      buf_valid_d = 1'b1;
      buf_inst_d  = inst_sram_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      pre_valid_q <= 1'b0;
      fs_valid_q  <= 1'b0;
      fs_pc_q     <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_inst_q  <= 32'd0;
    end else begin
      pre_valid_q <= pre_valid_d;
      fs_valid_q  <= fs_valid_d;
      fs_pc_q     <= fs_pc_d;
      buf_valid_q <= buf_valid_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  assign fs_to_ds_valid_o  = fs_valid_q && !br_taken_i;
  assign fs_to_ds_bus_o    = {fs_inst, fs_pc_q};
  assign inst_sram_en_o    = fetch_en;
  assign inst_sram_we_o    = 1'b0;
  assign inst_sram_addr_o  = nextpc;
  assign inst_sram_wdata_o = 32'd0;

endmodule
`default_nettype wire
